// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - column-serial AES MixColumns/InvMixColumns sequencer
// Optional MIX_COLS_PIPE_EN: registers the selected column before the mix_columns datapath.

module mix_columns (
  input  logic [31:0] col,
  output logic [31:0] enc,
  output logic [31:0] dec
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a  [4];
  logic [7:0] a2 [4];
  logic [7:0] a4 [4];
  logic [7:0] a8 [4];

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign a[i]  = col[31-8*i -: 8];
    assign a2[i] = xt(a[i]);
    assign a4[i] = xt(a2[i]);
    assign a8[i] = xt(a4[i]);
  end

  // Circulant rows: enc {2,3,1,1}, dec {14,11,13,9}, rotated per output row.
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign enc[31-8*r -: 8] = a2[r] ^ a2[(r+1)%4] ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
    assign dec[31-8*r -: 8] = (a8[r] ^ a4[r] ^ a2[r])
                            ^ (a8[(r+1)%4] ^ a2[(r+1)%4] ^ a[(r+1)%4])
                            ^ (a8[(r+2)%4] ^ a4[(r+2)%4] ^ a[(r+2)%4])
                            ^ (a8[(r+3)%4] ^ a[(r+3)%4]);
  end

endmodule

module mix_columns_seq #(
  parameter int NUM_COLS = 4,
  parameter int COL_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_COLS*COL_W-1:0] state_in,
  input  logic                      dec_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_COLS*COL_W-1:0] state_out,
  output logic                      busy
);

  localparam int STATE_W = NUM_COLS * COL_W;

  typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         col_cnt;
  logic               mode;
  logic [STATE_W-1:0] data;
  logic [COL_W-1:0]   mix_sel;
  logic [COL_W-1:0]   mix_in;
  logic [COL_W-1:0]   mix_enc;
  logic [COL_W-1:0]   mix_dec;
  logic [COL_W-1:0]   mix_res;
  logic [1:0]         wr_idx;
  logic               wr_en;
  logic               last_wr;
  logic               accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      mode <= 1'b0;
    end else if (accept) begin
      data <= state_in;
      mode <= dec_mode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt <= '0;
    end else if (accept) begin
      col_cnt <= '0;
    end else if (state == MIX) begin
      col_cnt <= col_cnt + 2'd1;
    end
  end

  always_comb begin
    mix_sel = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (col_cnt == 2'(i)) mix_sel = data[STATE_W-1-COL_W*i -: COL_W];
    end
  end

`ifdef MIX_COLS_PIPE_EN
  logic [COL_W-1:0] pipe_col;
  logic             fill;
  logic [1:0]       wr_cnt;

  // First MIX cycle only loads pipe_col; writes trail the mux by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_col <= '0;
      fill     <= 1'b0;
      wr_cnt   <= '0;
    end else if (accept) begin
      fill   <= 1'b1;
      wr_cnt <= '0;
    end else if (state == MIX) begin
      pipe_col <= mix_sel;
      fill     <= 1'b0;
      if (!fill) wr_cnt <= wr_cnt + 2'd1;
    end
  end

  assign mix_in = pipe_col;
  assign wr_en  = (state == MIX) && !fill;
  assign wr_idx = wr_cnt;
`else
  assign mix_in = mix_sel;
  assign wr_en  = (state == MIX);
  assign wr_idx = col_cnt;
`endif

  assign last_wr = wr_en && (wr_idx == 2'(NUM_COLS-1));

  mix_columns u_mix (
    .col (mix_in),
    .enc (mix_enc),
    .dec (mix_dec)
  );

  assign mix_res = mode ? mix_dec : mix_enc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_out <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        if (wr_idx == 2'(i)) state_out[STATE_W-1-COL_W*i -: COL_W] <= mix_res;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MIX;
      MIX:     if (last_wr) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
